neopixel_frame_sequencer: RTL
=============================

# neopixel_frame_sequencer

Upstream stage of `NeopixelController`. Holds a frame of NUM_PIXELS 24-bit GRB colours in a register array written by the game/display logic. On a `show` request it streams every pixel, index 0 first, into the controller over the `input_data`/`go`/`ready` handshake. It then enforces the WS2812 latch gap before another frame can start.

## Interface
- `NUM_PIXELS`, 16, pixels per frame (≥2)
- `LATCH_CYCLES`, 3000, idle cycles after the last pixel (60 µs at 50 MHz)
- `CLOCK_50  in  1`  system clock, 50 MHz
- `reset  in  1`  one clock; reset is synchronous and active-high
- `wr_en  in  1`  pixel write strobe
- `wr_addr  in  $clog2(NUM_PIXELS)`  pixel index to write
- `wr_data  in  24`  colour {G,R,B}, 8 bits each
- `show  in  1`  one-cycle request to transmit the whole frame
- `busy  out  1`  frame transmission or latch in progress
- `frame_done  out  1`  one-cycle pulse when the latch gap ends
- `input_data  out  24`  pixel to controller, registered
- `go  out  1`  one-cycle start strobe to controller
- `ready  in  1`  controller idle and able to accept `go`

## Operation
- States: IDLE, LOAD, SEND, GAP, WAITRDY, LATCH, DONE. `idx` counter is $clog2(NUM_PIXELS) bits; `latch_cnt` is $clog2(LATCH_CYCLES+1) bits.
- IDLE:
  - `wr_en` with `wr_addr < NUM_PIXELS` writes `mem[wr_addr]` at the clock edge.
  - An out-of-range `wr_addr` is ignored.
  - `show` → LOAD, with `idx` ← 0.
- LOAD: `input_data` ← `mem[idx]`; next state SEND.
- SEND: `go = (state==SEND) & ready` (combinational).
  - If `ready` is high, go to GAP.
  - If `ready` is low, stay in SEND with `go` low. The data is held.
- GAP: exactly one cycle; `ready` is ignored. The controller contract is that `ready` drops no later than the cycle after `go`.
- WAITRDY: wait for `ready` high.
  - If `idx == NUM_PIXELS-1`: go to LATCH with `latch_cnt` ← 0.
  - Otherwise: `idx` ← `idx`+1 and go to LOAD.
- LATCH: `latch_cnt` increments each cycle. When it reaches LATCH_CYCLES-1, go to DONE.
- DONE: `frame_done` = 1 for one cycle; next state IDLE.
- `busy = (state != IDLE)`.
- While `busy`: `wr_en` writes are dropped (no tearing), and `show` is ignored (not queued).
- `wr_en` and `show` in the same IDLE cycle: the write lands, and the frame sent contains the new value.
- Reset, from any state:
  - state → IDLE, `idx` = 0, counters = 0.
  - All `mem` entries = 24'h0.
  - `input_data` = 0, `go` = 0, `busy` = 0, `frame_done` = 0.
  - A partial frame is abandoned; no `frame_done` is issued for it.

## Timing
- `show` sampled at edge t: `busy` is high from t+1 and `input_data` is valid from t+2. `go` is at the earliest in cycle t+2, if `ready` is high.
- `input_data` is stable from the LOAD edge until the next LOAD edge, so it covers the whole controller transaction.
- Per-pixel overhead outside the controller's busy time: 3 cycles (LOAD, SEND, GAP).
- From the last `ready` rise seen in WAITRDY, `frame_done` pulses exactly LATCH_CYCLES+1 cycles later. `busy` falls on the cycle after `frame_done`.
- A new `show` is accepted on the first cycle back in IDLE.
- `go` never asserts outside SEND, and never on two consecutive cycles.

## Structure
- Package `neopixel_pkg`:
  - `pixel_t` packed struct {g,r,b} with 8-bit fields, GRB order.
  - `seq_state_t` enum.
  - `DEFAULT_LATCH_CYCLES` = 3000.
  - `PIXEL_W` = 24.
- One sub-module, `pixel_ram`: NUM_PIXELS × `pixel_t` register array.
  - Synchronous write with enable and range check.
  - Asynchronous read by index.
  - Synchronous clear on `reset`.
- FSM, counters and handshake live in `neopixel_frame_sequencer`.

## Test plan
- NUM_PIXELS=4, LATCH_CYCLES=10. Write 0x0000FF, 0x00FF00, 0xFF0000, 0x123456 to indices 0..3. Pulse `show`. The controller model drops `ready` for 24 cycles after each `go`. Required response:
  - four `go` pulses carrying the data in index order;
  - `frame_done` exactly 11 cycles after the final `ready` rise;
  - `busy` low the next cycle.
- `ready` held low for 7 cycles when `show` arrives → `go` stays low and `input_data` = mem[0] until `ready` rises. Then `go` pulses for exactly one cycle.
- During `busy`: write 0xABCDEF to index 1 and pulse `show` → index 1 is unchanged. A second `show` after `frame_done` transmits the old value, and only one frame is sent per accepted `show`.
- NUM_PIXELS=5 with `wr_addr`=7 (out of range, so `wr_data` = 0xFFFFFF must be ignored) → no entry changes, and the subsequent frame shows all original values.
- `reset` asserted during the second pixel's WAITRDY → `busy`, `go`, `input_data` = 0 the next cycle. No `frame_done` is issued. A following `show` sends all-zero pixels.
- `wr_en`(idx 0, 0x0A0B0C) and `show` in the same cycle → the first `go` carries 0x0A0B0C.

Source files
------------

// File: rtl/neopixel_pkg.sv
// Shared types and constants for the NeoPixel frame sequencer.
package neopixel_pkg;

    localparam int unsigned PIXEL_W              = 24;
    localparam int unsigned DEFAULT_LATCH_CYCLES = 3000;

    // One WS2812 colour, transmitted G first, then R, then B.
    typedef struct packed {
        logic [7:0] g;
        logic [7:0] r;
        logic [7:0] b;
    } pixel_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SEND,
        GAP,
        WAITRDY,
        LATCH,
        DONE
    } seq_state_t;

endpackage

// File: rtl/pixel_ram.sv
// Frame buffer: synchronous range-checked write, asynchronous read, cleared on reset.
module pixel_ram
    import neopixel_pkg::*;
#(
    parameter  int unsigned NUM_PIXELS = 16,
    localparam int unsigned ADDR_W     = $clog2(NUM_PIXELS)
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  pixel_t            wr_data,
    input  logic [ADDR_W-1:0] rd_idx,
    output pixel_t            rd_data
);

    pixel_t mem [NUM_PIXELS];

    // Write port; addresses past the last pixel are dropped.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            for (int i = 0; i < int'(NUM_PIXELS); i++) begin
                mem[ADDR_W'(i)] <= '0;
            end
        end else if (wr_en && (32'(wr_addr) < NUM_PIXELS)) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = (32'(rd_idx) < NUM_PIXELS) ? mem[rd_idx] : '0;

endmodule

// File: rtl/neopixel_frame_sequencer.sv
// Streams a stored frame of pixels into the NeoPixel controller, then holds the latch gap.
module neopixel_frame_sequencer
    import neopixel_pkg::*;
#(
    parameter  int unsigned NUM_PIXELS   = 16,
    parameter  int unsigned LATCH_CYCLES = DEFAULT_LATCH_CYCLES,
    localparam int unsigned ADDR_W       = $clog2(NUM_PIXELS),
    localparam int unsigned CNT_W        = $clog2(LATCH_CYCLES + 1)
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    input  logic               wr_en,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [PIXEL_W-1:0] wr_data,
    input  logic               show,
    output logic               busy,
    output logic               frame_done,
    output logic [PIXEL_W-1:0] input_data,
    output logic               go,
    input  logic               ready
);

    seq_state_t        state, state_nxt;
    logic [ADDR_W-1:0] idx, idx_nxt;
    logic [CNT_W-1:0]  latch_cnt, cnt_nxt;
    pixel_t            data_q, data_nxt;
    pixel_t            rd_data;

    // Writes only land while idle so a frame in flight is never torn.
    pixel_ram #(
        .NUM_PIXELS (NUM_PIXELS)
    ) u_ram (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .wr_en    (wr_en && (state == IDLE)),
        .wr_addr  (wr_addr),
        .wr_data  (pixel_t'(wr_data)),
        .rd_idx   (idx),
        .rd_data  (rd_data)
    );

    assign input_data = data_q;

    // State, pixel index, latch counter and outgoing pixel register.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= '0;
            latch_cnt <= '0;
            data_q    <= '0;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            latch_cnt <= cnt_nxt;
            data_q    <= data_nxt;
        end
    end

    // Next-state and handshake decode.
    always_comb begin
        state_nxt  = state;
        idx_nxt    = idx;
        cnt_nxt    = latch_cnt;
        data_nxt   = data_q;
        go         = 1'b0;
        frame_done = 1'b0;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                if (show) begin
                    state_nxt = LOAD;
                    idx_nxt   = '0;
                end
            end
            LOAD: begin
                data_nxt  = rd_data;
                state_nxt = SEND;
            end
            SEND: begin
                if (ready) begin
                    go        = 1'b1;
                    state_nxt = GAP;
                end
            end
            // Controller may still show ready the cycle after go; skip it.
            GAP: begin
                state_nxt = WAITRDY;
            end
            WAITRDY: begin
                if (ready) begin
                    if (32'(idx) == NUM_PIXELS - 1) begin
                        cnt_nxt   = '0;
                        state_nxt = LATCH;
                    end else begin
                        idx_nxt   = idx + ADDR_W'(1);
                        state_nxt = LOAD;
                    end
                end
            end
            LATCH: begin
                if (latch_cnt == CNT_W'(LATCH_CYCLES - 1)) begin
                    state_nxt = DONE;
                end else begin
                    cnt_nxt = latch_cnt + CNT_W'(1);
                end
            end
            DONE: begin
                frame_done = 1'b1;
                state_nxt  = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule
